l1_wb_mst: RTL
==============

// Module: l1_wb_mst
// PURPOSE
//  Parametrised L1 memory access unit: round-robin arbiter of N_CH L1 clients onto one Wishbone B4 pipelined master.
//  Line refill reads are multi-beat; non-cacheable reads and writes are single-beat.
//  Up to MAX_OUT transactions in flight. Sits between l1i/l1d caches and the system bus.
// PARAMETERS
//  N_CH    2    number of client channels (ch0 = highest priority after reset)
//  ADDR_W  32   address width
//  DATA_W  32   bus data width; BE_W = DATA_W/8
//  LINE_W  256  cache line width; BEATS = LINE_W/DATA_W, power of 2, >= 2
//  MAX_OUT 2    outstanding transaction queue depth, power of 2
// PORTS
//  wb_clk_i   in   1             clock
//  rst_n      in   1             reset, asynchronous, active-low
//  req_val    in   N_CH          request valid, held until req_ack
//  req_we     in   N_CH          1 = write (single beat)
//  req_nc     in   N_CH          1 = non-cacheable read (single beat); ignored when req_we=1
//  req_addr   in   N_CH*ADDR_W   byte address, channel c at [c*ADDR_W +: ADDR_W]
//  req_wdata  in   N_CH*DATA_W   write data
//  req_be     in   N_CH*BE_W     write byte enables
//  req_ack    out  N_CH          one-cycle completion pulse, one-hot or zero
//  ack_err    out  1             valid with req_ack: some beat ended in wb_err_i/wb_rty_i
//  ack_data   out  LINE_W        response data, valid with req_ack, held until next req_ack
//  wb_dat_i/wb_ack_i/wb_err_i/wb_rty_i/wb_stall_i  in  DATA_W/1/1/1/1  slave signals
//  wb_adr_o/wb_dat_o/wb_sel_o  out  ADDR_W/DATA_W/BE_W  master address, data, select
//  wb_cyc_o/wb_stb_o/wb_we_o   out  1                   master cycle, strobe, write enable
// BEHAVIOUR
//  - Reset: all outputs 0, queue empty, RR pointer = ch0. Reset mid-burst aborts it; no req_ack is issued for aborted transactions.
//  - Eligible channel: req_val=1 and no transaction in flight for it. At most one per channel.
//  - Arbitration is round-robin, starting after the last granted channel. A grant happens only when:
//    * the issue FSM is IDLE,
//    * the queue is not full,
//    * at least one channel is eligible.
//  - Issue FSM IDLE->ISSUE on grant. ISSUE holds BEATS_LEFT (BEATS for line read, 1 otherwise).
//  - ISSUE->IDLE when the last beat is accepted (stb_o & ~stall_i).
//  - Outputs are registered. stb_o rises the cycle after grant. adr/dat/sel/we are held while stall_i=1.
//  - Line read addr: low log2(LINE_W/8) bits forced 0, then +BE_W per accepted beat.
//    Beat k of a line read lands at ack_data[k*DATA_W +: DATA_W].
//  - NC read: addr as given, sel all-ones, data at ack_data[DATA_W-1:0], upper bits 0.
//  - Write: we_o=1, sel_o=req_be, dat_o=req_wdata. ack_data is not updated.
//  - On grant, {ch_id, beats} is pushed to the queue. Each wb_ack_i/err/rty retires one beat of the queue head.
//    When the head's final beat retires: req_ack[ch_id] pulses next cycle, ack_err = OR of err|rty over its beats, head is popped.
//    Error beats do not stop the burst; all beats are still issued and counted.
//  - cyc_o = stb_o | queue non-empty. It drops the cycle after the last retire if nothing new is issued.
//  - Simultaneous final retire (pop) and grant (push) while the queue is full: the push is allowed.
//  - wb_ack_i with an empty queue is ignored.
//  - A client dropping req_val before req_ack: the transaction still completes and pulses req_ack.
//  - Minimum latency, NC read with a zero-wait slave: grant c0, stb c1, ack c2, req_ack c3.
// STRUCTURE
//  - Package l1_mau_pkg: enum req_type_e {RT_LINE, RT_NC, RT_WR}, BEATS/BE_W/cnt-width localparams, queue entry struct {ch_id, type, beats_left}.
//  - Sub-module l1_rr_arb #(N_CH): req, en -> one-hot grant, updates pointer on grant.
//  - Outstanding queue reuses the existing fifo module, WIDTH = entry width, DEPTH = MAX_OUT.
// TESTING
//  1. ch0 line read addr 0x1004, no stall, acks 0..7 = 0xA0..0xA7:
//     adr_o 0x1000..0x101C, req_ack=01, ack_data[31:0]=0xA0, ack_data[255:224]=0xA7, ack_err=0.
//  2. ch0 and ch1 raise req_val the same cycle, repeated 4x:
//     grants alternate 0,1,0,1; each channel never has 2 in flight.
//  3. wb_stall_i=1 for 3 cycles on beat 2 of a line read:
//     adr_o/stb_o held constant, 8 beats total, single req_ack.
//  4. ch1 write addr 0x20 be=0x3 wdata=0xDEADBEEF, then NC read addr 0x24 returning 0x55:
//     we_o=1, sel_o=0x3 on the write; ack_data=0x55 with req_ack=10.
//  5. wb_err_i on beat 5 of a line read: 8 beats retired, ack_err=1 with req_ack.
//     With MAX_OUT=2 and 3 channels requesting, the third grant waits for the first pop.
//  6. rst_n low during beat 3 of a burst: all outputs 0 within the reset, no req_ack.
//     After release, a fresh request completes normally.

Source files
------------

// File: rtl/l1_mau_pkg.sv
// l1_mau_pkg: shared types and sizing helpers for the L1 memory access unit.
//   req_type_e : kind of client transaction (line refill, non-cacheable read, write)
//   q_entry_t  : one outstanding-queue entry {ch_id, rtype, beats}
//   beats_of   : beats per cache line for a given line/bus width
//   be_w_of    : byte-enable width for a given bus width
package l1_mau_pkg;

  typedef enum logic [1:0] {
    RT_LINE = 2'd0,
    RT_NC   = 2'd1,
    RT_WR   = 2'd2
  } req_type_e;

  // Entry fields are sized for up to 16 channels and up to 255 beats per line.
  localparam int CH_W  = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [CH_W-1:0]  ch_id;
    req_type_e        rtype;
    logic [CNT_W-1:0] beats;
  } q_entry_t;

  localparam int ENTRY_W = $bits(q_entry_t);

  function automatic int beats_of(input int line_w, input int data_w);
    return line_w / data_w;
  endfunction

  function automatic int be_w_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through queue.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write side; a push while full is accepted only together with a pop
//   pop, dout   read side; dout shows the head whenever empty=0
//   empty, full occupancy flags
// DEPTH must be a power of two and at least 2.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset on purpose; only the pointers and count decide
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/l1_rr_arb.sv
// l1_rr_arb: round-robin arbiter.
//   wb_clk_i, rst_n  clock, asynchronous active-low reset
//   req              per-channel request
//   en               arbitration allowed this cycle
//   gnt              one-hot grant (zero when en=0 or no request)
// Search starts at the channel after the last one granted; after reset the
// pointer sits on the last channel so ch0 has top priority.
module l1_rr_arb #(
  parameter int N_CH = 2
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            en,
  output logic [N_CH-1:0] gnt
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] gnt_idx;
  int               idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt = '0;
    idx = 0;
    if (en) begin
      for (int i = 1; i <= N_CH; i++) begin
        idx = (int'(last_q) + i) % N_CH;
        if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) gnt_idx = PTR_W'(c);
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)    last_q <= PTR_W'(N_CH - 1);
    else if (|gnt) last_q <= gnt_idx;
  end

endmodule

// File: rtl/l1_wb_mst.sv
// l1_wb_mst: arbitrates N_CH L1 clients onto one Wishbone B4 pipelined master.
//   wb_clk_i, rst_n                 clock, asynchronous active-low reset
//   req_val/we/nc/addr/wdata/be     client requests, held until req_ack
//   req_ack, ack_err, ack_data      one-cycle completion pulse, error flag, line/NC data
//   wb_dat_i/ack_i/err_i/rty_i/stall_i  slave response and flow control
//   wb_adr_o/dat_o/sel_o/cyc_o/stb_o/we_o  registered master request
// Line refills issue BEATS beats; NC reads and writes issue one. Each grant
// pushes {ch_id, type, beats} to the outstanding queue; responses retire beats
// of the queue head in order, and the head's last beat pops it and pulses
// req_ack the following cycle.
module l1_wb_mst
  import l1_mau_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LINE_W  = 256,
  parameter int MAX_OUT = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_val,
  input  logic [N_CH-1:0]          req_we,
  input  logic [N_CH-1:0]          req_nc,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  input  logic [N_CH*DATA_W/8-1:0] req_be,
  output logic [N_CH-1:0]          req_ack,
  output logic                     ack_err,
  output logic [LINE_W-1:0]        ack_data,
  input  logic [DATA_W-1:0]        wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic                     wb_stall_i,
  output logic [ADDR_W-1:0]        wb_adr_o,
  output logic [DATA_W-1:0]        wb_dat_o,
  output logic [DATA_W/8-1:0]      wb_sel_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o
);

  localparam int BE_W   = be_w_of(DATA_W);
  localparam int BEATS  = beats_of(LINE_W, DATA_W);
  localparam int LINE_B = LINE_W / 8;
  localparam int BIDX_W = $clog2(BEATS);

  typedef enum logic {S_IDLE, S_ISSUE} iss_state_e;

  iss_state_e state_q, state_d;

  logic [N_CH-1:0]   in_flight, eligible, gnt, done_vec;
  logic              arb_en, grant, accept;
  logic              q_empty, q_full, q_push, q_pop;
  logic [ENTRY_W-1:0] q_dout;
  q_entry_t          push_e, head_e;
  logic              retire, final_beat, beat_err;
  logic [CNT_W-1:0]  rx_cnt, beats_left;
  logic              err_acc;
  logic [LINE_W-1:0] rx_buf, line_next;

  // Request of the granted channel
  logic              sel_we, sel_nc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic [CH_W-1:0]   sel_ch;
  req_type_e         sel_type;

  // ---------------- arbitration ----------------
  assign eligible = req_val & ~in_flight;
  assign retire     = (wb_ack_i | wb_err_i | wb_rty_i) & ~q_empty;
  assign beat_err   = wb_err_i | wb_rty_i;
  assign final_beat = retire & (rx_cnt == head_e.beats - 1'b1);
  assign q_pop      = final_beat;
  // A full queue may still accept a grant when its head pops the same cycle.
  assign arb_en     = (state_q == S_IDLE) & (~q_full | q_pop);
  assign grant      = |gnt;
  assign q_push     = grant;
  assign accept     = wb_stb_o & ~wb_stall_i;

  l1_rr_arb #(.N_CH(N_CH)) u_arb (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .req      (eligible),
    .en       (arb_en),
    .gnt      (gnt)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_nc    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_ch    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) begin
        sel_we    = req_we[c];
        sel_nc    = req_nc[c];
        sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[c*DATA_W +: DATA_W];
        sel_be    = req_be[c*BE_W +: BE_W];
        sel_ch    = CH_W'(c);
      end
    end
  end

  assign sel_type = sel_we ? RT_WR : (sel_nc ? RT_NC : RT_LINE);

  always_comb begin
    push_e.ch_id = sel_ch;
    push_e.rtype = sel_type;
    push_e.beats = (sel_type == RT_LINE) ? CNT_W'(BEATS) : CNT_W'(1);
  end

  fifo #(.WIDTH(ENTRY_W), .DEPTH(MAX_OUT)) u_outq (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (push_e),
    .pop   (q_pop),
    .dout  (q_dout),
    .empty (q_empty),
    .full  (q_full)
  );

  assign head_e = q_entry_t'(q_dout);

  // ---------------- issue FSM ----------------
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: if (accept && (beats_left == CNT_W'(1))) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Master request registers: loaded on grant, held while stalled, address
  // stepped by one bus word per accepted beat.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      beats_left <= '0;
    end else if (grant) begin
      wb_stb_o   <= 1'b1;
      wb_we_o    <= sel_we;
      wb_adr_o   <= (sel_type == RT_LINE) ? (sel_addr & ~ADDR_W'(LINE_B - 1)) : sel_addr;
      wb_dat_o   <= sel_we ? sel_wdata : '0;
      wb_sel_o   <= sel_we ? sel_be : '1;
      beats_left <= push_e.beats;
    end else if (accept) begin
      if (beats_left == CNT_W'(1)) begin
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
      end else begin
        wb_adr_o <= wb_adr_o + ADDR_W'(BE_W);
      end
      beats_left <= beats_left - 1'b1;
    end
  end

  assign wb_cyc_o = wb_stb_o | ~q_empty;

  // ---------------- response path ----------------
  // Refill beats collect in rx_buf so ack_data stays stable until the next
  // completion; the final beat is merged on the way into ack_data.
  always_comb begin
    line_next = rx_buf;
    line_next[rx_cnt[BIDX_W-1:0]*DATA_W +: DATA_W] = wb_dat_i;
  end

  assign done_vec = final_beat ? (N_CH'(1) << head_e.ch_id) : '0;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt    <= '0;
      err_acc   <= 1'b0;
      rx_buf    <= '0;
      req_ack   <= '0;
      ack_err   <= 1'b0;
      ack_data  <= '0;
      in_flight <= '0;
    end else begin
      req_ack <= done_vec;
      // A channel stays blocked through its req_ack cycle, so a client still
      // holding req_val that cycle cannot be granted twice.
      in_flight <= (in_flight | gnt) & ~req_ack;
      if (retire) begin
        if (head_e.rtype == RT_LINE) rx_buf <= line_next;
        if (final_beat) begin
          rx_cnt  <= '0;
          err_acc <= 1'b0;
          ack_err <= err_acc | beat_err;
          case (head_e.rtype)
            RT_LINE: ack_data <= line_next;
            RT_NC:   ack_data <= LINE_W'(wb_dat_i);
            default: ;
          endcase
        end else begin
          rx_cnt  <= rx_cnt + 1'b1;
          err_acc <= err_acc | beat_err;
        end
      end
    end
  end

endmodule
